// File: rtl/cpu_out_uart.sv
// cpu_out_uart: buffers 4-bit CPU output-register writes in a small FIFO and
// serialises each one as an 8N1 UART frame on tx (LSB first, idle high).
// Optional build macro CPU_OUT_UART_HEX_ASCII_EN: when defined, each nibble is
// sent as its uppercase ASCII hex character; otherwise as {4'b0000, nibble}.
module cpu_out_uart #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       wr,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       baud_cnt, baud_next;
  logic [2:0]       bit_idx, bit_next;
  logic [7:0]       shift, shift_next;
  logic             tx_next;
  logic             empty, pop, push, baud_done;

  // Map a nibble onto the byte that goes out on the wire.
  function automatic logic [7:0] frame_byte(input logic [3:0] nib);
`ifdef CPU_OUT_UART_HEX_ASCII_EN
    frame_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
`else
    frame_byte = {4'b0000, nib};
`endif
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign busy      = (state != IDLE) || !empty;
  assign baud_done = (baud_cnt == BAUD_LAST);
  // The FSM only pops from IDLE, so a pop always frees a slot for a write
  // arriving on the same edge even when the FIFO is full.
  assign pop       = (state == IDLE) && !empty;
  assign push      = wr && (!full || pop);

  // FIFO storage write port.
  // NOTE: the storage array is not reset; the pointers and occupancy counter
  // define which entries are valid, so clearing the array would only add logic.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= din;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && full && !pop) overflow <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic.
  // NOTE: every signal assigned in a combinational block gets a default first
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!empty)                         state_next = START;
      START: if (baud_done)                      state_next = DATA;
      DATA:  if (baud_done && bit_idx == 3'd7)   state_next = STOP;
      STOP:  if (baud_done)                      state_next = IDLE;
      default:                                   state_next = IDLE;
    endcase
  end

  // FSM output logic: next values for baud counter, bit index, shifter and tx.
  always_comb begin
    baud_next  = baud_cnt + 8'd1;
    bit_next   = bit_idx;
    shift_next = shift;
    if (state_next != state || state == IDLE || baud_done) baud_next = '0;
    case (state)
      IDLE: begin
        if (pop) begin
          shift_next = frame_byte(mem[rd_ptr]);
          bit_next   = '0;
        end
      end
      START: if (baud_done) bit_next = '0;
      DATA: begin
        if (baud_done) begin
          shift_next = {1'b0, shift[7:1]};
          bit_next   = bit_idx + 3'd1;
        end
      end
      default: ;
    endcase
    // tx is registered from the state being entered, so START drives low on
    // the same edge that pops the FIFO.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // Datapath registers, including the glitch-free tx output.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
    end
  end

endmodule

// File: tb/tb_cpu_out_uart.sv
// tb_cpu_out_uart: scoreboard bench for cpu_out_uart (CLKS_PER_BIT=4,
// FIFO_DEPTH=4). Accepted writes push their expected frame byte; a line
// monitor checks every cycle of each frame against the head of the queue.
module tb_cpu_out_uart;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = 4'h0;
  logic       wr  = 1'b0;
  logic       tx, busy, full, overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q [$];
  int         start_q [$];

  bit         mon_active = 1'b0;
  int         mon_cnt;
  int         mon_b;
  int         frames_done = 0;
  logic [7:0] mon_exp;
  logic [7:0] mon_rx;
  logic       mon_lvl;
  bit         mon_bad;

  cpu_out_uart #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .wr(wr),
    .tx(tx), .busy(busy), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_byte(input logic [3:0] n);
`ifdef CPU_OUT_UART_HEX_ASCII_EN
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n} - 8'd10;
`else
    return {4'h0, n};
`endif
  endfunction

  // Line monitor: samples tx 2 time units after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        start_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, expected no frame", cyc);
          mon_exp = 8'h00;
        end else begin
          mon_exp = exp_q.pop_front();
        end
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_bad    = 1'b0;
        mon_rx     = 8'h00;
      end
    end else begin
      mon_cnt++;
      mon_b = mon_cnt / 4;
      if (mon_b == 0)      mon_lvl = 1'b0;
      else if (mon_b <= 8) mon_lvl = mon_exp[mon_b-1];
      else                 mon_lvl = 1'b1;
      if (mon_b >= 1 && mon_b <= 8 && (mon_cnt % 4) == 2) mon_rx[mon_b-1] = tx;
      if (tx !== mon_lvl) mon_bad = 1'b1;
      if (mon_cnt == 39) begin
        checks++;
        frames_done++;
        if (mon_bad) begin
          errors++;
          $display("FAIL frame: got byte %h (or bad level/timing), expected %h", mon_rx, mon_exp);
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_drain(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy && !mon_active) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b1; din = 4'h5;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, full, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state: tx/busy/full/ovf=%b, expected 1000", {tx, busy, full, overflow});
    end
    rst = 1'b0; wr = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (start_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr_ignored: frames=%0d busy=%b, expected 0 and 0", start_q.size(), busy);
    end
  endtask

  task automatic test_single();
    int k;
    bit to;
    start_q.delete();
    wr = 1'b1; din = 4'hA; exp_q.push_back(exp_byte(4'hA));
    @(negedge clk);
    wr = 1'b0; k = cyc;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pre: tx=%b busy=%b, expected 1 1", tx, busy);
    end
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
    end
    checks++;
    if (to || cyc != k + 41) begin
      errors++;
      $display("FAIL busy_fall: busy low at cycle %0d (timeout=%b), expected %0d", cyc, to, k + 41);
    end
    checks++;
    if (start_q.size() != 1 || start_q[0] != k + 1) begin
      errors++;
      $display("FAIL latency: %0d starts, first at %0d, expected 1 start at %0d",
               start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, k + 1);
    end
    wait_drain(to);
    checks++;
    if (to || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: timeout=%b pending=%0d, expected 0 0", to, exp_q.size());
    end
  endtask

  task automatic test_burst();
    bit to;
    start_q.delete();
    for (int v = 1; v <= 5; v++) begin
      wr = 1'b1; din = 4'(v); exp_q.push_back(exp_byte(4'(v)));
      @(negedge clk);
    end
    wr = 1'b0;
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL burst_full: full=%b, expected 1", full);
    end
    wait_drain(to);
    checks++;
    if (to || exp_q.size() != 0 || start_q.size() != 5 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL burst_drain: timeout=%b pending=%0d frames=%0d ovf=%b, expected 0 0 5 0",
               to, exp_q.size(), start_q.size(), overflow);
    end
    for (int i = 1; i < start_q.size(); i++) begin
      checks++;
      if (start_q[i] - start_q[i-1] != 41) begin
        errors++;
        $display("FAIL burst_gap: frame %0d spacing %0d cycles, expected 41", i, start_q[i] - start_q[i-1]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [3:0] vals [4] = '{4'h8, 4'h9, 4'hB, 4'hC};
    bit to;
    wr = 1'b1; din = 4'h6; exp_q.push_back(exp_byte(4'h6));
    @(negedge clk);
    wr = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; din = vals[i]; exp_q.push_back(exp_byte(vals[i]));
      @(negedge clk);
    end
    wr = 1'b1; din = 4'h7;
    @(negedge clk);
    wr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b full=%b, expected 1 1", overflow, full);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b, expected 1", overflow);
    end
    wait_drain(to);
    checks++;
    if (to || exp_q.size() != 0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drain: timeout=%b pending=%0d ovf=%b, expected 0 0 1", to, exp_q.size(), overflow);
    end
  endtask

  task automatic test_reset_midframe();
    int k;
    wr = 1'b1; din = 4'h3; exp_q.push_back(exp_byte(4'h3));
    @(negedge clk);
    k = cyc;
    din = 4'h4; exp_q.push_back(exp_byte(4'h4));
    @(negedge clk);
    din = 4'h5; exp_q.push_back(exp_byte(4'h5));
    @(negedge clk);
    wr = 1'b0;
    while (cyc < k + 18) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({tx, busy, full, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_midframe: tx/busy/full/ovf=%b, expected 1000", {tx, busy, full, overflow});
    end
    rst = 1'b0;
    start_q.delete();
    repeat (60) @(negedge clk);
    checks++;
    if (start_q.size() != 0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_frames: frames=%0d tx=%b, expected 0 1", start_q.size(), tx);
    end
  endtask

  task automatic test_edge_write();
    int k;
    bit to;
    wr = 1'b1; din = 4'h0; exp_q.push_back(exp_byte(4'h0));
    @(negedge clk);
    k = cyc;
    for (int v = 1; v <= 4; v++) begin
      din = 4'(v); exp_q.push_back(exp_byte(4'(v)));
      @(negedge clk);
    end
    wr = 1'b0;
    while (cyc < k + 41) @(negedge clk);
    checks++;
    if (full !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL edge_pre: full=%b tx=%b in idle cycle, expected 1 1", full, tx);
    end
    wr = 1'b1; din = 4'hF; exp_q.push_back(exp_byte(4'hF));
    @(negedge clk);
    wr = 1'b0;
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL edge_write: full=%b ovf=%b, expected 1 0", full, overflow);
    end
    wait_drain(to);
    checks++;
    if (to || exp_q.size() != 0) begin
      errors++;
      $display("FAIL edge_drain: timeout=%b pending=%0d, expected 0 0", to, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reset_midframe();
    test_edge_write();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_out_uart.md
CPU_OUT_UART -- requirements
Module: cpu_out_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clk cycles per UART bit period (legal range 2..255).
REQ-002 Parameter FIFO_DEPTH, default 4, number of nibble entries buffered (power of two, 2..16).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 din  input  4  nibble from the CPU output-register data path (same value latched into port_out).
REQ-006 wr  input  1  write strobe, asserted by the CPU in the same cycle as the output-register load (lo).
REQ-007 tx  output  1  UART serial line; idle high.
REQ-008 busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-009 full  output  1  high when the FIFO holds FIFO_DEPTH entries.
REQ-010 overflow  output  1  sticky flag; a write was dropped.

Function
REQ-011 A write SHALL be accepted on a rising edge where wr=1 and full=0, or where wr=1, full=1 and a pop occurs on that same edge.
REQ-012 A write with wr=1 and full=1 and no same-edge pop SHALL be discarded, set overflow to 1, and leave the FIFO unchanged.
REQ-013 The FIFO SHALL be first-in first-out; read and write pointers wrap modulo FIFO_DEPTH; an occupancy counter of width log2(FIFO_DEPTH)+1 SHALL drive full and empty.
REQ-014 A simultaneous push and pop SHALL leave occupancy unchanged; a simultaneous push and pop on an empty FIFO is impossible (no pop while empty).
REQ-015 The FSM SHALL have the states IDLE, START, DATA, and STOP.
REQ-016 IDLE: tx=1. When the FIFO is non-empty: pop the head, load the 8-bit frame byte into the shift register, and go to START on the same edge.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-018 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit; after 8 bits go to STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-020 A frame SHALL be exactly 10*CLKS_PER_BIT cycles; data is sent LSB first.
REQ-021 Latency: a write accepted at edge k into an idle, empty block SHALL produce tx=0 from edge k+1.
REQ-022 Back-to-back frames: IDLE lasts exactly one cycle (tx=1) between a STOP and the next START when the FIFO is non-empty.
REQ-023 tx SHALL be driven from a register (glitch-free).
REQ-024 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state change.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL enter IDLE with tx=1, busy=0, full=0, overflow=0, FIFO empty, pointers 0, and counters 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately (tx=1 from the next edge); buffered entries are lost.
REQ-027 A wr asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-028 Macro CPU_OUT_UART_HEX_ASCII_EN selects the frame-byte encoding.
- Defined: the frame byte SHALL be the ASCII hex character of the nibble: 0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46 (uppercase).
- Undefined: the frame byte SHALL be {4'b0000, nibble}.
- All other behaviour is identical in both builds.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single write, HEX_ASCII_EN defined: din=4'hA, wr pulse at edge k.
- Required response: tx=0 for cycles k+1..k+4, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop=1.
- busy falls after edge k+40.
REQ-030 Same stimulus, macro undefined.
- Required response: data bits 0,1,0,1,0,0,0,0 (byte 8'h0A).
REQ-031 Burst of 5 writes (1,2,3,4,5) on consecutive edges from idle.
- All five are accepted, because the first is popped at the next edge.
- full=1 after the fifth write.
- Five frames follow in order, each separated by one idle cycle; overflow stays 0.
REQ-032 Overflow: with the FIFO full and the FSM mid-DATA, write 4'h7.
- Required response: overflow=1 and sticky; the FIFO contents are unchanged; 4'h7 is never transmitted.
REQ-033 Reset mid-frame: assert rst for 1 cycle during DATA bit 3 with 2 entries queued.
- Required response: tx=1 from the next edge, busy=0, full=0, overflow=0, and no further frames.
REQ-034 Edge write: with the FIFO full, assert wr in the cycle an IDLE pop occurs.
- Required response: the write is accepted, full stays 1, and overflow stays 0.
